// File: rtl/cg_rvarch_instr_encoder.sv
// RV32 base instruction encoder: field-level requests in, 32-bit words out
// through a small valid/ready output FIFO carrying a per-word error flag.
module cg_rvarch_instr_encoder #(
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [6:0]          i_opcode,
    input  logic [4:0]          i_rd,
    input  logic [4:0]          i_rs1,
    input  logic [4:0]          i_rs2,
    input  logic [2:0]          i_funct3,
    input  logic [6:0]          i_funct7,
    input  logic [31:0]         i_imm,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [31:0]         o_instr,
    output logic                o_err,
    output logic [ERRCNT_W-1:0] o_err_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    logic signed [31:0] imm_s;
    logic               i_range_bad;
    logic               b_range_bad;
    logic               j_range_bad;
    logic [31:0]        enc_instr;
    logic               enc_err;

    assign imm_s       = i_imm;
    assign i_range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
    assign b_range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || i_imm[0];
    assign j_range_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || i_imm[0];

    always_comb begin
        enc_instr = 32'h0;
        enc_err   = 1'b0;
        case (i_opcode)
            OP_OP, OP_OP_32: begin
                enc_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            OP_LOAD, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
                enc_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_err   = i_range_bad;
            end
            OP_STORE: begin
                enc_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_err   = i_range_bad;
            end
            OP_BRANCH: begin
                enc_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                enc_err   = b_range_bad;
            end
            OP_LUI, OP_AUIPC: begin
                enc_instr = {i_imm[31:12], i_rd, i_opcode};
                enc_err   = (i_imm[11:0] != 12'h0);
            end
            OP_JAL: begin
                enc_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                enc_err   = j_range_bad;
            end
            default: begin
                enc_instr = 32'h0;
                enc_err   = 1'b1;
            end
        endcase
    end

    logic [31:0]         instr_mem_q [DEPTH];
    logic [31:0]         instr_mem_d [DEPTH];
    logic                err_mem_q   [DEPTH];
    logic                err_mem_d   [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                push;
    logic                pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_ready   = (count_q < CW'(DEPTH));
    assign o_valid   = (count_q != '0);
    assign push      = i_valid & o_ready;
    assign pop       = o_valid & i_ready;
    assign o_instr   = o_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign o_err     = o_valid ? err_mem_q[rd_ptr_q] : 1'b0;
    assign o_err_cnt = err_cnt_q;

    always_comb begin
        instr_mem_d = instr_mem_q;
        err_mem_d   = err_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_cnt_d   = err_cnt_q;
        if (push) begin
            instr_mem_d[wr_ptr_q] = enc_instr;
            err_mem_d[wr_ptr_q]   = enc_err;
            wr_ptr_d              = ptr_next(wr_ptr_q);
            if (enc_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is left unreset; the head is masked to zero while empty.
    always_ff @(posedge i_clk) begin
        instr_mem_q <= instr_mem_d;
        err_mem_q   <= err_mem_d;
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_cg_rvarch_instr_encoder.sv
// Directed bench for cg_rvarch_instr_encoder: hand-encoded words, error
// flags, error counter, backpressure ordering and mid-stream reset.
module tb_cg_rvarch_instr_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic        o_err;
    logic [15:0] o_err_cnt;

    int checks   = 0;
    int failures = 0;

    cg_rvarch_instr_encoder #(.DEPTH(2), .ERRCNT_W(16)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_opcode  (i_opcode),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_funct3  (i_funct3),
        .i_funct7  (i_funct7),
        .i_imm     (i_imm),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_instr   (o_instr),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        i_valid  = 1'b1;
        i_opcode = op;
        i_rd     = rd;
        i_rs1    = rs1;
        i_rs2    = rs2;
        i_funct3 = f3;
        i_funct7 = f7;
        i_imm    = imm;
    endtask

    // One request through an empty FIFO with the consumer ready.
    task automatic one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input logic exp_err);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        step();
        i_valid = 1'b0;
        check({tag, ".valid"}, 32'(o_valid), 32'd1);
        check({tag, ".instr"}, o_instr, exp_instr);
        check({tag, ".err"}, 32'(o_err), 32'(exp_err));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        i_rst   = 1'b1;
        i_ready = 1'b1;
        drive(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        i_valid = 1'b0;
        repeat (3) step();
        i_rst = 1'b0;
        step();

        check("rst.valid", 32'(o_valid), 32'd0);
        check("rst.instr", o_instr, 32'h0);
        check("rst.err", 32'(o_err), 32'd0);
        check("rst.cnt", 32'(o_err_cnt), 32'd0);
        check("rst.ready", 32'(o_ready), 32'd1);

        one("addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        check("addi.drain", 32'(o_valid), 32'd0);

        drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check("sw.instr", o_instr, 32'h0020A423);
        check("sw.valid", 32'(o_valid), 32'd1);
        step();
        i_valid = 1'b0;
        check("add.instr", o_instr, 32'h002081B3);
        check("add.valid", 32'(o_valid), 32'd1);
        step();
        check("b2b.drain", 32'(o_valid), 32'd0);

        one("jal", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0);
        one("lui", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        check("cnt.zero", 32'(o_err_cnt), 32'd0);

        one("beq.odd", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 1'b1);
        check("cnt.one", 32'(o_err_cnt), 32'd1);
        one("addi.2048", 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000013, 1'b1);
        check("cnt.two", 32'(o_err_cnt), 32'd2);
        one("badop", 7'b1101011, 5'd3, 5'd1, 5'd2, 3'd1, 7'd1, 32'd4, 32'h00000000, 1'b1);
        check("cnt.three", 32'(o_err_cnt), 32'd3);
        one("addi.m2048", 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000013, 1'b0);
        one("beq.4094", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E000FE3, 1'b0);
        one("lui.low", 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00001037, 1'b1);
        check("cnt.four", 32'(o_err_cnt), 32'd4);

        i_ready = 1'b0;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        check("bp.ready1", 32'(o_ready), 32'd1);
        check("bp.headA", o_instr, 32'h00100093);
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        step();
        check("bp.full", 32'(o_ready), 32'd0);
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        check("bp.still_full", 32'(o_ready), 32'd0);
        check("bp.stable", o_instr, 32'h00100093);
        i_ready = 1'b1;
        step();
        check("bp.ready_after_pop", 32'(o_ready), 32'd1);
        check("bp.headB", o_instr, 32'h00200093);
        step();
        i_valid = 1'b0;
        check("bp.headC", o_instr, 32'h00300093);
        check("bp.validC", 32'(o_valid), 32'd1);
        step();
        check("bp.drain", 32'(o_valid), 32'd0);

        i_ready = 1'b0;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        step();
        drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        step();
        i_valid = 1'b0;
        check("pre_rst.full", 32'(o_ready), 32'd0);
        check("pre_rst.cnt", 32'(o_err_cnt), 32'd5);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("mid_rst.valid", 32'(o_valid), 32'd0);
        check("mid_rst.cnt", 32'(o_err_cnt), 32'd0);
        check("mid_rst.ready", 32'(o_ready), 32'd1);
        check("mid_rst.instr", o_instr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
